// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: run-state encoding
// and a width helper for prescaler counters.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } seg_state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int seg_clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Clock-enable prescaler: emits a one-cycle tick every DIV enabled cycles.
// The count freezes while en is low and is zeroed by clr.
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              PW   = seg_clog2w(DIV);
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_reg;

  assign tick = en && !clr && (cnt_reg == LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + PW'(1);
    end
  end

endmodule

// File: rtl/seg_run_counter.sv
// Start/pause/clear controlled modulo counter for one display digit group,
// advancing on prescaled ticks and emitting a wrap pulse for cascading.
module seg_run_counter
  import seg_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 8,
  parameter int CNT_MOD = 256
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_clear,
  input  logic             up_dn,
  output logic [CNT_W-1:0] cout_cnt,
  output logic             running,
  output logic             wrap
);

  localparam int               DIV  = CLK_HZ / TICK_HZ;
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(CNT_MOD - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("seg_run_counter: CLK_HZ/TICK_HZ must be at least 1");
    end
    if (CNT_MOD < 2 || CNT_MOD > (2 ** CNT_W)) begin : g_bad_mod
      $error("seg_run_counter: CNT_MOD must lie in 2..2**CNT_W");
    end
  endgenerate

  seg_state_t state_reg;
  logic       raw_tick;
  logic       tick;
  logic       presc_en;
  logic       presc_clr;

  assign presc_en  = (state_reg == ST_RUN);
  // Zeroing throughout IDLE also covers the IDLE->RUN entry edge.
  assign presc_clr = (state_reg == ST_IDLE) || key_clear;

  seg_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .en       (presc_en),
    .clr      (presc_clr),
    .tick     (raw_tick)
  );

  // Key pulses take precedence over a coincident tick.
  assign tick = raw_tick && !key_start && !key_clear;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cout_cnt  <= '0;
      running   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (key_clear) begin
        state_reg <= ST_IDLE;
        cout_cnt  <= '0;
        running   <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (key_start) begin
              state_reg <= ST_RUN;
              running   <= 1'b1;
            end
          end
          ST_RUN: begin
            if (key_start) begin
              state_reg <= ST_PAUSE;
              running   <= 1'b0;
            end else if (tick) begin
              if (up_dn) begin
                if (cout_cnt == TOP) begin
                  cout_cnt <= '0;
                  wrap     <= 1'b1;
                end else begin
                  cout_cnt <= cout_cnt + CNT_W'(1);
                end
              end else begin
                if (cout_cnt == '0) begin
                  cout_cnt <= TOP;
                  wrap     <= 1'b1;
                end else begin
                  cout_cnt <= cout_cnt - CNT_W'(1);
                end
              end
            end
          end
          ST_PAUSE: begin
            if (key_start) begin
              state_reg <= ST_RUN;
              running   <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            running   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_run_counter.sv
// Directed bench for seg_run_counter: a DIV=10 decade counter and a DIV=1
// byte counter, checked through an expected-value queue.
module tb_seg_run_counter;

  logic       CLOCK_50;
  logic       rst_n;
  logic       a_start, a_clr, a_up;
  logic       b_start, b_clr, b_up;
  logic [3:0] a_cnt;
  logic [7:0] b_cnt;
  logic       a_running, a_wrap, b_running, b_wrap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  seg_run_counter #(
    .CLK_HZ (10), .TICK_HZ (1), .CNT_W (4), .CNT_MOD (10)
  ) dut_a (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .key_start (a_start),
    .key_clear (a_clr),
    .up_dn     (a_up),
    .cout_cnt  (a_cnt),
    .running   (a_running),
    .wrap      (a_wrap)
  );

  seg_run_counter #(
    .CLK_HZ (1), .TICK_HZ (1), .CNT_W (8), .CNT_MOD (256)
  ) dut_b (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .key_start (b_start),
    .key_clear (b_clr),
    .up_dn     (b_up),
    .cout_cnt  (b_cnt),
    .running   (b_running),
    .wrap      (b_wrap)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0d required=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        bad++;
        $error("FAIL %s observed=%0d required=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic push3(input string tag, input int c, input int r, input int w);
    push({tag, ".cnt"}, c);
    push({tag, ".run"}, r);
    push({tag, ".wrap"}, w);
  endtask

  // Push expectations, advance n cycles, then compare DUT A outputs.
  task automatic step_a(input int n, input string tag, input int c, input int r, input int w);
    push3({"a.", tag}, c, r, w);
    cyc(n);
    $display("a %s cnt=%0d run=%0d wrap=%0d", tag, a_cnt, a_running, a_wrap);
    pop_chk({28'd0, a_cnt});
    pop_chk({31'd0, a_running});
    pop_chk({31'd0, a_wrap});
  endtask

  task automatic step_b(input int n, input string tag, input int c, input int r, input int w);
    push3({"b.", tag}, c, r, w);
    cyc(n);
    $display("b %s cnt=%0d run=%0d wrap=%0d", tag, b_cnt, b_running, b_wrap);
    pop_chk({24'd0, b_cnt});
    pop_chk({31'd0, b_running});
    pop_chk({31'd0, b_wrap});
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0; a_clr = 1'b0; a_up = 1'b1;
    b_start = 1'b0; b_clr = 1'b0; b_up = 1'b1;

    step_a(2, "reset", 0, 0, 0);
    step_b(0, "reset", 0, 0, 0);
    rst_n = 1'b1;

    // Start, first increments, wrap going up
    cyc(4);
    a_start = 1'b1;
    step_a(1, "start", 0, 1, 0);
    a_start = 1'b0;
    step_a(9, "pre_tick", 0, 1, 0);
    step_a(1, "cnt1", 1, 1, 0);
    step_a(10, "cnt2", 2, 1, 0);
    step_a(70, "cnt9", 9, 1, 0);
    step_a(10, "wrap_up", 0, 1, 1);
    step_a(1, "wrap_gone", 0, 1, 0);

    // Pause four cycles after a tick, hold, resume with preserved prescaler
    step_a(29, "cnt3", 3, 1, 0);
    cyc(3);
    a_start = 1'b1;
    step_a(1, "pause", 3, 0, 0);
    a_start = 1'b0;
    step_a(50, "hold", 3, 0, 0);
    a_start = 1'b1;
    step_a(1, "resume", 3, 1, 0);
    a_start = 1'b0;
    step_a(5, "resume5", 3, 1, 0);
    step_a(1, "resume6", 4, 1, 0);

    // Count down through zero, then an up_dn glitch between ticks
    a_up = 1'b0;
    step_a(40, "down0", 0, 1, 0);
    step_a(10, "wrap_down", 9, 1, 1);
    step_a(10, "down8", 8, 1, 0);
    a_up = 1'b1;
    cyc(5);
    a_up = 1'b0;
    step_a(5, "down7", 7, 1, 0);

    // Clear and start together on a tick edge
    cyc(9);
    a_start = 1'b1;
    a_clr   = 1'b1;
    step_a(1, "clr_start", 0, 0, 0);
    a_start = 1'b0;
    a_clr   = 1'b0;
    step_a(20, "idle", 0, 0, 0);

    // Asynchronous reset between edges at count 5
    a_up    = 1'b1;
    a_start = 1'b1;
    step_a(1, "start2", 0, 1, 0);
    a_start = 1'b0;
    step_a(50, "cnt5", 5, 1, 0);
    #2 rst_n = 1'b0;
    step_a(0, "pre_async", 5, 1, 0);
    push3("a.async_rst", 0, 0, 0);
    #1;
    $display("a async_rst cnt=%0d run=%0d wrap=%0d", a_cnt, a_running, a_wrap);
    pop_chk({28'd0, a_cnt});
    pop_chk({31'd0, a_running});
    pop_chk({31'd0, a_wrap});
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    step_a(30, "post_rst", 0, 0, 0);
    a_start = 1'b1;
    step_a(1, "start3", 0, 1, 0);
    a_start = 1'b0;
    step_a(10, "cnt1b", 1, 1, 0);

    // DIV=1 byte counter: every cycle, wrap at 255, reversal, pause
    b_start = 1'b1;
    step_b(1, "start", 0, 1, 0);
    b_start = 1'b0;
    step_b(1, "cnt1", 1, 1, 0);
    step_b(254, "cnt255", 255, 1, 0);
    step_b(1, "wrap_up", 0, 1, 1);
    step_b(1, "cnt1b", 1, 1, 0);
    b_up = 1'b0;
    step_b(1, "down0", 0, 1, 0);
    step_b(1, "wrap_down", 255, 1, 1);
    step_b(1, "cnt254", 254, 1, 0);
    b_start = 1'b1;
    step_b(1, "pause", 254, 0, 0);
    b_start = 1'b0;
    step_b(5, "hold", 254, 0, 0);

    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_run_counter.md
Name: seg_run_counter

Overview:
- Parametrised run counter that drives the 7-segment display datapath.
- Counts at a programmable tick rate derived from CLOCK_50 via an internal clock-enable prescaler; no derived clocks.
- Key-flag pulses control it: start/pause toggle and clear. It supports up/down direction and a programmable modulus with a wrap pulse for cascading digits.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be >= 1 (elaboration error otherwise).
- CNT_W, 8, counter width in bits.
- CNT_MOD, 256, count modulus; legal range 2..2^CNT_W (elaboration error otherwise).

Ports:
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_start  in  1  one-cycle debounced key pulse; toggles run/pause.
- key_clear  in  1  one-cycle debounced key pulse; returns to idle, count 0.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled only on tick cycles.
- cout_cnt  out  CNT_W  current count value (registered).
- running  out  1  high while in RUN state (registered).
- wrap  out  1  one-cycle pulse on the edge where the count wraps (registered).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cout_cnt=0, running=0, wrap=0, prescaler=0. Reset mid-count discards everything. First edge after deassertion behaves as IDLE.
- FSM states IDLE, RUN, PAUSE; transitions on CLOCK_50 edges:
  - key_clear=1 in any state -> IDLE, cout_cnt<=0, prescaler<=0, wrap<=0. key_clear has priority over key_start and over a coincident tick.
  - IDLE + key_start -> RUN, prescaler<=0.
  - RUN + key_start -> PAUSE. A tick in the same cycle is suppressed; the count holds.
  - PAUSE + key_start -> RUN. The prescaler resumes from its held value with no restart.
  - Otherwise hold state.
- Prescaler (0..DIV-1): increments only in RUN; holds in PAUSE; forced 0 in IDLE. tick = RUN && prescaler==DIV-1 && !key_start && !key_clear. On tick the prescaler goes to 0.
- Latency: key_start sampled at edge k (IDLE) -> running=1 after edge k. First count change after edge k+DIV. Successive changes every DIV cycles. With DIV=1, the count changes every cycle in RUN.
- Count on tick, up (up_dn=1): cout_cnt==CNT_MOD-1 -> 0 with wrap=1; else +1.
- Count on tick, down (up_dn=0): cout_cnt==0 -> CNT_MOD-1 with wrap=1; else -1.
- wrap is 0 on every non-wrapping cycle.
- Changing up_dn between ticks has no effect until the next tick.
- cout_cnt holds in PAUSE and IDLE. Any value < CNT_MOD is legal; no saturation.
- Arithmetic is CNT_W bits unsigned. The prescaler width is clog2(DIV) bits (minimum 1).

Decomposition:
- Shared package seg_pkg: FSM state enum (IDLE/RUN/PAUSE, 2-bit) and a clog2 width helper function for the prescaler, reused by other display blocks.
- One sub-module: seg_tick_gen.
  - Inputs: CLOCK_50, rst_n, en, clr.
  - Output: one-cycle tick.
  - Parameter: DIV.
  - Holds its count when en=0 and zeroes it when clr=1.
- The top level instantiates seg_tick_gen with en = RUN and clr = (IDLE or entering RUN from IDLE or key_clear), then gates the tick with the key pulses.

Test Plan (CLK_HZ=10, TICK_HZ=1 -> DIV=10; CNT_W=4, CNT_MOD=10 unless noted):
- Reset then key_start at cycle 5, up_dn=1 -> running=1 from cycle 6; cout_cnt 1 at cycle 15, 2 at cycle 25. After 10 ticks cout_cnt=0 with wrap high exactly one cycle.
- Run to 3, pulse key_start 4 cycles after a tick -> PAUSE, count holds 3 for 50 cycles. Second key_start -> RUN; next increment to 4 arrives 6 cycles after resume.
- Count 0 in RUN with up_dn=0 -> next tick gives 9 with wrap=1. Following tick gives 8 with wrap=0.
- key_clear and key_start in the same cycle during RUN at count 7 -> IDLE, cout_cnt=0, running=0, no tick. Coincident tick is dropped.
- Assert rst_n=0 asynchronously mid-RUN at count 5 (between clock edges) -> cout_cnt, running, wrap go 0 immediately. After release, idles until key_start.
- DIV=1 (CLK_HZ=TICK_HZ), CNT_W=8, CNT_MOD=256 -> counts every cycle, 255->0 with wrap. Toggling up_dn mid-run reverses direction on the next cycle.
